// File: rtl/arb_rr_quantum.sv
// Round-robin arbiter whose pointer skips idle requesters and caps each grant at a quantum.
// Define ARB_RR_WEIGHT_EN to take the per-requester quantum from the weight port.
module arb_rr_quantum #(
    parameter int REQ_NUM = 4,
    parameter int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    parameter int CNT_W   = 4,
    parameter int QUANTUM = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REQ_NUM-1:0]       req,
    input  logic [REQ_NUM*CNT_W-1:0] weight,
    output logic [REQ_NUM-1:0]       grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     q_expire
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_d;
    logic [IDX_W-1:0]     ptr, ptr_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [REQ_NUM-1:0]   grant_d;
    logic [IDX_W-1:0]     idx_d;
    logic                 q_expire_d;

    logic                 found;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W:0]       cand;
    logic [IDX_W-1:0]     ptr_after_sel;
    logic [CNT_W-1:0]     q_eff;

    // First requester at or after ptr, wrapping at REQ_NUM rather than 2^IDX_W.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(REQ_NUM))
                cand = cand - (IDX_W+1)'(REQ_NUM);
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
    end

    assign ptr_after_sel = (sel == IDX_W'(REQ_NUM-1)) ? '0 : sel + 1'b1;

`ifdef ARB_RR_WEIGHT_EN
    logic [CNT_W-1:0] w_sel;
    assign w_sel = weight[grant_idx*CNT_W +: CNT_W];
    assign q_eff = (w_sel == '0) ? CNT_W'(1) : w_sel;
`else
    logic unused_weight;
    assign unused_weight = ^weight;
    assign q_eff = CNT_W'(QUANTUM);
`endif

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        cnt_d      = cnt;
        grant_d    = grant;
        idx_d      = grant_idx;
        q_expire_d = 1'b0;
        case (state)
            IDLE: begin
                grant_d = '0;
                if (found) begin
                    grant_d[sel] = 1'b1;
                    idx_d        = sel;
                    cnt_d        = CNT_W'(1);
                    ptr_d        = ptr_after_sel;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                // A voluntary drop wins over expiry when both land on the same edge.
                if (!req[grant_idx]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (cnt == q_eff) begin
                    grant_d    = '0;
                    q_expire_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            grant     <= '0;
            grant_idx <= '0;
            q_expire  <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            grant     <= grant_d;
            grant_idx <= idx_d;
            q_expire  <= q_expire_d;
        end
    end

endmodule
